// File: rtl/dm_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types, line geometry and address-field helpers for the
//            direct-mapped cache controller.
// Revision : 1.0
// ============================================================================
package cache_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITEBACK   = 3'd1,
        REFILL_REQ  = 3'd2,
        REFILL_WAIT = 3'd3,
        RESPOND     = 3'd4
    } state_t;

    // Word select within the 16-byte line.
    function automatic logic [1:0] addr_offset(input logic [31:0] addr);
        return 2'(addr >> 2);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
        return (addr >> 4) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
        return addr >> (4 + index_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl_if
// Brief    : Core-side request/response and memory-side line bus of one cache.
// Revision : 1.0
// ============================================================================
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]              cpu_addr;
    logic                           cpu_re;
    logic [3:0]                     cpu_we;
    logic [31:0]                    cpu_din;
    logic [31:0]                    cpu_dout;
    logic                           stall;
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic                           mem_req_rw;
    logic [ADDR_W-5:0]              mem_req_addr;
    logic [cache_pkg::LINE_BITS-1:0] mem_req_data;
    logic                           mem_resp_valid;
    logic [cache_pkg::LINE_BITS-1:0] mem_resp_data;

    // master = the cache controller, slave = core plus memory around it
    modport master (
        input  cpu_addr, cpu_re, cpu_we, cpu_din,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_dout, stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );

    modport slave (
        output cpu_addr, cpu_re, cpu_we, cpu_din,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_dout, stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );
endinterface
`default_nettype wire

// File: rtl/dm_cache_ctrl_store.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_store
// Brief    : Valid/dirty/tag/data flop arrays with combinational read,
//            full-line refill write and byte-masked word write.
// Revision : 1.0
// ============================================================================
module cache_line_store
    import cache_pkg::*;
#(
    parameter  int LINES   = 64,
    parameter  int TAG_W   = 22,
    localparam int INDEX_W = $clog2(LINES)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [INDEX_W-1:0]   rd_index,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [TAG_W-1:0]          rd_tag,
    output logic [LINE_BITS-1:0]      rd_data,
    input  wire logic [INDEX_W-1:0]   wr_index,
    input  wire logic                 line_we,
    input  wire logic [TAG_W-1:0]     line_tag,
    input  wire logic [LINE_BITS-1:0] line_data,
    input  wire logic                 word_we,
    input  wire logic [1:0]           word_sel,
    input  wire logic [3:0]           word_be,
    input  wire logic [WORD_BITS-1:0] word_data
);

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];

    assign rd_valid = r_valid[rd_index];
    assign rd_dirty = r_dirty[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (line_we) begin
            r_valid[wr_index] <= 1'b1;
            r_dirty[wr_index] <= 1'b0;
        end else if (word_we) begin
            r_dirty[wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            r_tag[wr_index]  <= line_tag;
            r_data[wr_index] <= line_data;
        end else if (word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (word_be[b]) begin
                    r_data[wr_index][int'(word_sel)*WORD_BITS + b*8 +: 8] <= word_data[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Brief    : Direct-mapped write-back write-allocate cache controller with a
//            single-beat 128-bit line interface to memory.
// Revision : 1.0
// ============================================================================
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int ADDR_W = 32
) (
    input wire logic        clk,
    input wire logic        reset,
    dm_cache_ctrl_if.master bus
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - 4 - INDEX_W;

    state_t               r_state;
    state_t               w_next;
    logic                 r_pend;
    logic [ADDR_W-1:0]    r_addr;
    logic [3:0]           r_we;
    logic [31:0]          r_din;
    logic [31:0]          r_dout;

    logic [INDEX_W-1:0]   w_index;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_off;
    logic                 w_rd_valid;
    logic                 w_rd_dirty;
    logic [TAG_W-1:0]     w_rd_tag;
    logic [LINE_BITS-1:0] w_rd_data;
    logic [31:0]          w_word;
    logic                 w_hit;
    logic                 w_access;
    logic                 w_read_done;
    logic                 w_write_done;
    logic                 w_capture;
    logic                 w_stall;
    logic                 w_line_we;
    logic                 w_mem_valid;
    logic                 w_mem_rw;
    logic [ADDR_W-5:0]    w_mem_addr;
    logic [LINE_BITS-1:0] w_mem_data;

    assign w_index = INDEX_W'(addr_index(32'(r_addr), INDEX_W));
    assign w_tag   = TAG_W'(addr_tag(32'(r_addr), INDEX_W));
    assign w_off   = addr_offset(32'(r_addr));
    assign w_word  = w_rd_data[int'(w_off)*WORD_BITS +: WORD_BITS];
    assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);

    // RESPOND always completes: the line was installed on the previous edge.
    assign w_access     = (r_state == IDLE && r_pend && w_hit) || (r_state == RESPOND);
    assign w_read_done  = w_access && (r_we == 4'b0000);
    assign w_write_done = w_access && (r_we != 4'b0000);
    assign w_capture    = (r_state == IDLE) && !w_stall && (bus.cpu_re || (bus.cpu_we != 4'b0000));

    cache_line_store #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (w_index),
        .rd_valid  (w_rd_valid),
        .rd_dirty  (w_rd_dirty),
        .rd_tag    (w_rd_tag),
        .rd_data   (w_rd_data),
        .wr_index  (w_index),
        .line_we   (w_line_we),
        .line_tag  (w_tag),
        .line_data (bus.mem_resp_data),
        .word_we   (w_write_done),
        .word_sel  (w_off),
        .word_be   (r_we),
        .word_data (r_din)
    );

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_line_we   = 1'b0;
        w_mem_valid = 1'b0;
        w_mem_rw    = 1'b0;
        w_mem_addr  = '0;
        w_mem_data  = '0;
        case (r_state)
            IDLE: begin
                if (r_pend && !w_hit) begin
                    w_stall = 1'b1;
                    w_next  = (w_rd_valid && w_rd_dirty) ? WRITEBACK : REFILL_REQ;
                end
            end
            WRITEBACK: begin
                w_stall     = 1'b1;
                w_mem_valid = 1'b1;
                w_mem_rw    = 1'b1;
                w_mem_addr  = {w_rd_tag, w_index};
                w_mem_data  = w_rd_data;
                if (bus.mem_req_ready) w_next = REFILL_REQ;
            end
            REFILL_REQ: begin
                w_stall     = 1'b1;
                w_mem_valid = 1'b1;
                w_mem_addr  = r_addr[ADDR_W-1:4];
                if (bus.mem_req_ready) w_next = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_resp_valid) begin
                    w_line_we = 1'b1;
                    w_next    = RESPOND;
                end
            end
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (w_read_done) r_dout <= w_word;
            if (w_capture) begin
                r_pend <= 1'b1;
                r_addr <= bus.cpu_addr;
                r_we   <= bus.cpu_we;
                r_din  <= bus.cpu_din;
            end else if (w_access) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.cpu_dout      = w_read_done ? w_word : r_dout;
    assign bus.stall         = w_stall;
    assign bus.mem_req_valid = w_mem_valid;
    assign bus.mem_req_rw    = w_mem_rw;
    assign bus.mem_req_addr  = w_mem_addr;
    assign bus.mem_req_data  = w_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_ctrl
// Brief    : Directed self-checking bench for dm_cache_ctrl (LINES=64).
// Revision : 1.0
// ============================================================================
module tb_dm_cache_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dm_cache_ctrl_if #(.ADDR_W(32)) bus ();

    dm_cache_ctrl #(
        .LINES  (64),
        .ADDR_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] c_L1    = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    localparam logic [127:0] c_L1_WB = {32'h33333333, 32'h22222222, 32'hDEABBEEF, 32'h11111111};
    localparam logic [127:0] c_L2    = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] c_L3    = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] c_JUNK  = {4{32'h5A5A5A5A}};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset              = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_re         = 1'b0;
        bus.cpu_we         = 4'b0000;
        bus.cpu_din        = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick();
        tick();
        check("rst_stall", 128'(bus.stall), 128'd0);
        check("rst_mvalid", 128'(bus.mem_req_valid), 128'd0);
        check("rst_rw", 128'(bus.mem_req_rw), 128'd0);
        check("rst_dout", 128'(bus.cpu_dout), 128'd0);
        reset = 1'b1;

        // Cold miss on 0x1004, no victim to write back
        bus.cpu_addr = 32'h0000_1004;
        bus.cpu_re   = 1'b1;
        tick();
        check("miss1_stall", 128'(bus.stall), 128'd1);
        check("miss1_noreq", 128'(bus.mem_req_valid), 128'd0);
        bus.mem_req_ready = 1'b1;
        tick();
        check("rreq1_valid", 128'(bus.mem_req_valid), 128'd1);
        check("rreq1_rw", 128'(bus.mem_req_rw), 128'd0);
        check("rreq1_addr", 128'(bus.mem_req_addr), 128'h0000100);
        check("rreq1_stall", 128'(bus.stall), 128'd1);
        tick();
        check("wait1_stall", 128'(bus.stall), 128'd1);
        check("wait1_noreq", 128'(bus.mem_req_valid), 128'd0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = c_L1;
        tick();
        check("resp1_dout", 128'(bus.cpu_dout), 128'hDEADBEEF);
        check("resp1_stall", 128'(bus.stall), 128'd0);
        bus.mem_resp_valid = 1'b0;
        bus.cpu_re         = 1'b0;
        tick();

        // Hit read, then hit store back-to-back, then read-after-write
        bus.cpu_addr = 32'h0000_1000;
        bus.cpu_re   = 1'b1;
        tick();
        check("hit0_dout", 128'(bus.cpu_dout), 128'h11111111);
        check("hit0_stall", 128'(bus.stall), 128'd0);
        bus.cpu_addr = 32'h0000_1004;
        bus.cpu_re   = 1'b0;
        bus.cpu_we   = 4'b0100;
        bus.cpu_din  = 32'h00AB0000;
        tick();
        check("st_stall", 128'(bus.stall), 128'd0);
        check("st_dout_hold", 128'(bus.cpu_dout), 128'h11111111);
        bus.cpu_we = 4'b0000;
        bus.cpu_re = 1'b1;
        tick();
        check("raw_dout", 128'(bus.cpu_dout), 128'hDEABBEEF);
        check("raw_stall", 128'(bus.stall), 128'd0);
        bus.cpu_re = 1'b0;
        tick();
        check("idle_hold", 128'(bus.cpu_dout), 128'hDEABBEEF);

        // Conflicting read 0x1404 forces write-back of the dirty line
        bus.cpu_addr = 32'h0000_1404;
        bus.cpu_re   = 1'b1;
        tick();
        check("miss2_stall", 128'(bus.stall), 128'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("wb_valid", 128'(bus.mem_req_valid), 128'd1);
            check("wb_rw", 128'(bus.mem_req_rw), 128'd1);
            check("wb_addr", 128'(bus.mem_req_addr), 128'h0000100);
            check("wb_data", bus.mem_req_data, c_L1_WB);
            check("wb_stall", 128'(bus.stall), 128'd1);
            check("wb_dout", 128'(bus.cpu_dout), 128'hDEABBEEF);
            if (i == 4) bus.mem_req_ready = 1'b1;
            tick();
        end
        check("rreq2_valid", 128'(bus.mem_req_valid), 128'd1);
        check("rreq2_rw", 128'(bus.mem_req_rw), 128'd0);
        check("rreq2_addr", 128'(bus.mem_req_addr), 128'h0000140);
        tick();
        check("wait2_stall", 128'(bus.stall), 128'd1);

        // Reset during REFILL_WAIT, then a late response must be ignored
        bus.mem_req_ready = 1'b0;
        bus.cpu_re        = 1'b0;
        reset             = 1'b0;
        tick();
        reset              = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = c_JUNK;
        check("mrst_stall", 128'(bus.stall), 128'd0);
        check("mrst_mvalid", 128'(bus.mem_req_valid), 128'd0);
        tick();
        check("late_stall", 128'(bus.stall), 128'd0);
        check("late_mvalid", 128'(bus.mem_req_valid), 128'd0);
        bus.mem_resp_valid = 1'b0;
        bus.cpu_re         = 1'b1;
        tick();
        check("miss3_stall", 128'(bus.stall), 128'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        check("rreq3_rw", 128'(bus.mem_req_rw), 128'd0);
        check("rreq3_addr", 128'(bus.mem_req_addr), 128'h0000140);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = c_L2;
        tick();
        check("resp3_dout", 128'(bus.cpu_dout), 128'hA1A1A1A1);
        check("resp3_stall", 128'(bus.stall), 128'd0);
        bus.mem_resp_valid = 1'b0;
        bus.cpu_re         = 1'b0;
        tick();

        // Clean victim: 0x1000 goes straight to refill
        bus.cpu_addr = 32'h0000_1000;
        bus.cpu_re   = 1'b1;
        tick();
        check("miss4_stall", 128'(bus.stall), 128'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        check("rreq4_rw", 128'(bus.mem_req_rw), 128'd0);
        check("rreq4_addr", 128'(bus.mem_req_addr), 128'h0000100);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = c_L3;
        tick();
        check("resp4_dout", 128'(bus.cpu_dout), 128'hC0C0C0C0);
        bus.mem_resp_valid = 1'b0;
        bus.cpu_re         = 1'b0;
        tick();

        // Back-to-back hits, one per cycle
        bus.cpu_addr = 32'h0000_1000;
        bus.cpu_re   = 1'b1;
        tick();
        check("b2b0_dout", 128'(bus.cpu_dout), 128'hC0C0C0C0);
        check("b2b0_stall", 128'(bus.stall), 128'd0);
        bus.cpu_addr = 32'h0000_1004;
        tick();
        check("b2b1_dout", 128'(bus.cpu_dout), 128'hC1C1C1C1);
        check("b2b1_stall", 128'(bus.stall), 128'd0);
        bus.cpu_addr = 32'h0000_1008;
        tick();
        check("b2b2_dout", 128'(bus.cpu_dout), 128'hC2C2C2C2);
        check("b2b2_stall", 128'(bus.stall), 128'd0);
        bus.cpu_re = 1'b0;
        tick();
        check("b2b_hold", 128'(bus.cpu_dout), 128'hC2C2C2C2);
        check("b2b_end_stall", 128'(bus.stall), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
